// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: sequencer states, opcode constants and
// instruction field slicers used by both the fetch unit and the decoder.
package fetch_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      HALT  = 2'd2
   } state_t;

   localparam logic [5:0] OP_HALT     = 6'h3F;
   localparam int         INSTR_BYTES = 4;

   function automatic logic [5:0] instr_op(input logic [31:0] w);
      return 6'(w >> 26);
   endfunction

   function automatic logic [4:0] instr_rs(input logic [31:0] w);
      return 5'(w >> 21);
   endfunction

   function automatic logic [4:0] instr_rt(input logic [31:0] w);
      return 5'(w >> 16);
   endfunction

   function automatic logic [4:0] instr_rd(input logic [31:0] w);
      return 5'(w >> 11);
   endfunction

   function automatic logic [4:0] instr_sa(input logic [31:0] w);
      return 5'(w >> 6);
   endfunction

   function automatic logic [15:0] instr_imm(input logic [31:0] w);
      return 16'(w);
   endfunction

   function automatic logic [25:0] instr_jaddr(input logic [31:0] w);
      return 26'(w);
   endfunction

endpackage

// File: rtl/word_assembler.sv
// Collects four bytes MSB-first into one instruction word; the last byte is
// passed straight through so the word is complete in the same cycle as done.
module word_assembler
   import fetch_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        clear,
   input  logic [7:0]  byte_in,
   output logic [1:0]  byte_cnt,
   output logic        done,
   output logic [31:0] word
);

   logic [1:0] cnt_reg;

   assign byte_cnt = cnt_reg;
   assign done     = en && !clear && (cnt_reg == 2'(INSTR_BYTES - 1));

   // Counter rolls 3 -> 0 on the final byte, ready for the next word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_reg <= 2'd0;
      end else if (clear) begin
         cnt_reg <= 2'd0;
      end else if (en) begin
         cnt_reg <= cnt_reg + 2'd1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < INSTR_BYTES - 1; gi++) begin : gen_slot
         logic [7:0] slot_reg;
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               slot_reg <= 8'h00;
            end else if (en && !clear && cnt_reg == 2'(gi)) begin
               slot_reg <= byte_in;
            end
         end
      end
   endgenerate

   assign word = {gen_slot[0].slot_reg, gen_slot[1].slot_reg, gen_slot[2].slot_reg, byte_in};

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction fetch: owns the PC, reads one byte per cycle from a
// byte-wide store and hands complete words to decode over valid/ready.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          ADDR_W   = 8,
   parameter logic [5:0]  HALT_OP  = OP_HALT
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [7:0]        mem_rdata,
   input  logic              redir_valid,
   input  logic [31:0]       redir_pc,
   output logic [31:0]       instr,
   output logic [31:0]       instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [31:0]       pc,
   output logic              halted
);

   state_t      state_reg;
   logic [31:0] pc_reg;
   logic [31:0] instr_reg;
   logic [31:0] instr_pc_reg;
   logic        instr_valid_reg;
   logic        halted_reg;

   logic [1:0]  byte_cnt;
   logic        asm_done;
   logic [31:0] asm_word;
   logic [31:0] redir_target;
   logic        in_fetch;

   assign in_fetch     = (state_reg == FETCH);
   assign redir_target = redir_pc & 32'hFFFF_FFFC;

   word_assembler u_asm (
      .clk      (clk),
      .reset    (reset),
      .en       (in_fetch),
      .clear    (in_fetch && redir_valid),
      .byte_in  (mem_rdata),
      .byte_cnt (byte_cnt),
      .done     (asm_done),
      .word     (asm_word)
   );

   assign mem_addr    = pc_reg[ADDR_W-1:0] + ADDR_W'(byte_cnt);
   // State is FETCH while reset is held, so the strobe is gated explicitly.
   assign mem_rd      = in_fetch && !reset;
   assign instr       = instr_reg;
   assign instr_pc    = instr_pc_reg;
   assign instr_valid = instr_valid_reg;
   assign pc          = pc_reg;
   assign halted      = halted_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg       <= FETCH;
         pc_reg          <= RESET_PC;
         instr_reg       <= 32'h0;
         instr_pc_reg    <= 32'h0;
         instr_valid_reg <= 1'b0;
         halted_reg      <= 1'b0;
      end else begin
         case (state_reg)
            FETCH: begin
               if (redir_valid) begin
                  pc_reg <= redir_target;
               end else if (asm_done) begin
                  instr_reg       <= asm_word;
                  instr_pc_reg    <= pc_reg;
                  instr_valid_reg <= 1'b1;
                  state_reg       <= HOLD;
               end
            end
            HOLD: begin
               if (instr_ready) begin
                  instr_valid_reg <= 1'b0;
                  // A delivered halt wins over a same-cycle redirect.
                  if (instr_op(instr_reg) == HALT_OP) begin
                     state_reg  <= HALT;
                     halted_reg <= 1'b1;
                  end else begin
                     pc_reg    <= redir_valid ? redir_target : pc_reg + 32'd4;
                     state_reg <= FETCH;
                  end
               end else if (redir_valid) begin
                  instr_valid_reg <= 1'b0;
                  pc_reg          <= redir_target;
                  state_reg       <= FETCH;
               end
            end
            HALT: begin
            end
            default: begin
               state_reg <= FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a word-level reference model is checked
// against the DUT every cycle, plus hand-computed checkpoints.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_rdata;
   logic        redir_valid;
   logic [31:0] redir_pc;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] pc;
   logic        halted;

   logic [7:0]  mem [256];

   int n_tests = 0;
   int n_fail  = 0;

   fetch_sequencer #(
      .RESET_PC (32'h0000_0000),
      .ADDR_W   (8),
      .HALT_OP  (6'h3F)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .mem_addr    (mem_addr),
      .mem_rd      (mem_rd),
      .mem_rdata   (mem_rdata),
      .redir_valid (redir_valid),
      .redir_pc    (redir_pc),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .pc          (pc),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] word_at(input logic [31:0] a);
      logic [31:0] w;
      w = 32'h0;
      for (int k = 0; k < 4; k++) begin
         w = {w[23:0], mem[8'(a[7:0] + 8'(k))]};
      end
      return w;
   endfunction

   task automatic put_word(input logic [7:0] a, input logic [31:0] w);
      for (int k = 0; k < 4; k++) begin
         mem[8'(a + 8'(k))] = 8'(w >> (24 - 8 * k));
      end
   endtask

   // Reference model: mode 0 = fetching, 1 = offering a word, 2 = stopped.
   int          m_mode;
   int          m_n;
   logic [31:0] m_pc;
   logic [31:0] m_word;
   logic [31:0] m_ipc;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_mode = 0;
         m_n    = 0;
         m_pc   = 32'h0;
         m_word = 32'h0;
         m_ipc  = 32'h0;
      end else begin
         case (m_mode)
            0: begin
               if (redir_valid) begin
                  m_pc = redir_pc & 32'hFFFF_FFFC;
                  m_n  = 0;
               end else begin
                  m_n++;
                  if (m_n == 4) begin
                     m_word = word_at(m_pc);
                     m_ipc  = m_pc;
                     m_n    = 0;
                     m_mode = 1;
                  end
               end
            end
            1: begin
               if (instr_ready) begin
                  if (m_word[31:26] == 6'h3F) begin
                     m_mode = 2;
                  end else begin
                     m_pc   = redir_valid ? (redir_pc & 32'hFFFF_FFFC) : m_pc + 32'd4;
                     m_mode = 0;
                  end
               end else if (redir_valid) begin
                  m_pc   = redir_pc & 32'hFFFF_FFFC;
                  m_mode = 0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         chk("rst_instr", instr, 32'h0);
         chk("rst_instr_pc", instr_pc, 32'h0);
         chk("rst_valid", {31'h0, instr_valid}, 32'h0);
         chk("rst_halted", {31'h0, halted}, 32'h0);
         chk("rst_mem_rd", {31'h0, mem_rd}, 32'h0);
         chk("rst_pc", pc, 32'h0);
      end else begin
         chk("cyc_valid", {31'h0, instr_valid}, {31'h0, m_mode == 1});
         chk("cyc_halted", {31'h0, halted}, {31'h0, m_mode == 2});
         chk("cyc_mem_rd", {31'h0, mem_rd}, {31'h0, m_mode == 0});
         chk("cyc_pc", pc, m_pc);
         if (m_mode == 0) chk("cyc_mem_addr", {24'h0, mem_addr}, {24'h0, 8'(m_pc[7:0] + 8'(m_n))});
         if (m_mode == 1) begin
            chk("cyc_instr", instr, m_word);
            chk("cyc_instr_pc", instr_pc, m_ipc);
         end
         if (instr_valid && instr_ready)
            $display("[TB] transfer pc=%h instr=%h redir=%0b", instr_pc, instr, redir_valid);
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
      put_word(8'h00, 32'h0401_0008);
      put_word(8'h04, 32'h4002_0002);
      put_word(8'h08, 32'h1122_3344);
      put_word(8'h1C, 32'h5566_7788);
      put_word(8'h30, 32'h8C43_0010);
      put_word(8'h40, 32'hFC00_0000);
      put_word(8'hFC, 32'hA1B2_C3D4);

      reset       = 1'b1;
      instr_ready = 1'b1;
      redir_valid = 1'b0;
      redir_pc    = 32'h0;
      step(3);
      chk("lit_reset_pc", pc, 32'h0);
      reset = 1'b0;

      // First word appears on the 4th edge after release.
      step(3);
      chk("lit_not_yet_valid", {31'h0, instr_valid}, 32'h0);
      step(1);
      chk("lit_first_valid", {31'h0, instr_valid}, 32'h1);
      chk("lit_first_instr", instr, 32'h0401_0008);
      chk("lit_first_pc", instr_pc, 32'h0);
      step(5);
      chk("lit_second_instr", instr, 32'h4002_0002);
      chk("lit_second_pc", instr_pc, 32'h4);

      // Back-pressure in HOLD.
      instr_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         chk("lit_hold_valid", {31'h0, instr_valid}, 32'h1);
         chk("lit_hold_instr", instr, 32'h4002_0002);
         chk("lit_hold_mem_rd", {31'h0, mem_rd}, 32'h0);
         chk("lit_hold_pc", pc, 32'h4);
      end
      instr_ready = 1'b1;
      step(1);
      instr_ready = 1'b0;
      chk("lit_one_xfer_valid", {31'h0, instr_valid}, 32'h0);
      chk("lit_one_xfer_pc", pc, 32'h8);

      // Redirect in HOLD without transfer drops the word.
      step(4);
      chk("lit_word8", instr, 32'h1122_3344);
      redir_valid = 1'b1;
      redir_pc    = 32'h0000_001E;
      step(1);
      redir_valid = 1'b0;
      chk("lit_hold_redir_valid", {31'h0, instr_valid}, 32'h0);
      chk("lit_hold_redir_pc", pc, 32'h1C);

      // Redirect together with a transfer.
      step(4);
      chk("lit_word1c_pc", instr_pc, 32'h1C);
      instr_ready = 1'b1;
      redir_valid = 1'b1;
      redir_pc    = 32'h0000_0030;
      step(1);
      instr_ready = 1'b0;
      redir_valid = 1'b0;
      chk("lit_xfer_redir_pc", pc, 32'h30);
      step(4);
      chk("lit_word30", instr, 32'h8C43_0010);
      chk("lit_word30_pc", instr_pc, 32'h30);

      // PC wrap at 2^32.
      instr_ready = 1'b1;
      redir_valid = 1'b1;
      redir_pc    = 32'hFFFF_FFFF;
      step(1);
      instr_ready = 1'b0;
      redir_valid = 1'b0;
      chk("lit_top_pc", pc, 32'hFFFF_FFFC);
      step(4);
      chk("lit_top_instr", instr, 32'hA1B2_C3D4);
      instr_ready = 1'b1;
      step(1);
      instr_ready = 1'b0;
      chk("lit_pc_wrap", pc, 32'h0);

      // Walk back to pc=8, then redirect after two bytes.
      step(4);
      instr_ready = 1'b1;
      step(5);
      step(1);
      instr_ready = 1'b0;
      chk("lit_back_at_8", pc, 32'h8);
      step(2);
      redir_valid = 1'b1;
      redir_pc    = 32'h0000_0041;
      step(1);
      redir_valid = 1'b0;
      chk("lit_fetch_redir_pc", pc, 32'h40);
      chk("lit_fetch_redir_addr", {24'h0, mem_addr}, 32'h40);
      step(4);
      chk("lit_halt_instr", instr, 32'hFC00_0000);
      chk("lit_halt_instr_pc", instr_pc, 32'h40);

      // Halt beats a simultaneous redirect; later redirects are ignored.
      instr_ready = 1'b1;
      redir_valid = 1'b1;
      redir_pc    = 32'h0000_0080;
      step(1);
      instr_ready = 1'b0;
      chk("lit_halted", {31'h0, halted}, 32'h1);
      chk("lit_halt_pc", pc, 32'h40);
      for (int i = 0; i < 6; i++) begin
         redir_valid = (i % 2 == 0);
         step(1);
         chk("lit_halt_stays", {31'h0, halted}, 32'h1);
         chk("lit_halt_no_rd", {31'h0, mem_rd}, 32'h0);
      end
      redir_valid = 1'b0;

      // Reset out of HALT, mid-FETCH and mid-HOLD.
      reset = 1'b1;
      #1;
      chk("lit_rst_halt_halted", {31'h0, halted}, 32'h0);
      chk("lit_rst_halt_pc", pc, 32'h0);
      step(1);
      reset = 1'b0;
      step(2);
      reset = 1'b1;
      #1;
      chk("lit_rst_fetch_rd", {31'h0, mem_rd}, 32'h0);
      chk("lit_rst_fetch_pc", pc, 32'h0);
      step(1);
      reset = 1'b0;
      step(4);
      chk("lit_restart_instr", instr, 32'h0401_0008);
      chk("lit_restart_pc", instr_pc, 32'h0);
      step(2);
      reset = 1'b1;
      #1;
      chk("lit_rst_hold_valid", {31'h0, instr_valid}, 32'h0);
      chk("lit_rst_hold_instr", instr, 32'h0);
      step(1);
      reset = 1'b0;
      instr_ready = 1'b1;
      step(12);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
